// File: rtl/cook_timer_pkg.sv
// cook_timer_pkg: shared types and default constants for the cook timer.
//   timer_state_t : IDLE, ARMED, RUN, PAUSE, DONE
//   SEC_DIV_DEF   : default clock cycles per one-second tick
//   TIME_W_DEF    : default width of the seconds counter
//   ADD_SEC_DEF   : default seconds added per quick-add press
package cook_timer_pkg;

  localparam int SEC_DIV_DEF = 100;
  localparam int TIME_W_DEF  = 12;
  localparam int ADD_SEC_DEF = 30;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } timer_state_t;

endpackage

// File: rtl/cook_timer_tick_gen.sv
// tick_gen: one-second prescaler for the cook timer.
//   clk   : system clock
//   rst   : asynchronous active-high reset (count returns to 0)
//   en    : advance the prescaler this cycle
//   clr   : force the prescaler to 0 (wins over en)
//   tick  : high on the enabled cycle that wraps SEC_DIV-1 back to 0
//   count : current prescaler value, 0 .. SEC_DIV-1
module tick_gen
  import cook_timer_pkg::*;
#(
  parameter int SEC_DIV = SEC_DIV_DEF,
  parameter int CW      = $clog2(SEC_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic          tick,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] LAST = CW'(SEC_DIV - 1);

  assign tick = en && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (count == LAST) count <= '0;
      else               count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cook_timer.sv
// cook_timer: cook-duration timer beside the oven controller.
//   Loads a time in seconds, counts down only while the controller's heat
//   is high, freezes while heat is low, and holds finish once time runs out.
//   Optional quick-add button is enabled with the macro COOK_TIMER_ADD_EN.
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   set_valid : load strobe, set_time valid when high
//   set_time  : cook duration in seconds
//   clear     : abort, back to IDLE
//   heat      : heating-active from the oven controller
//   add_time  : quick-add strobe (only with COOK_TIMER_ADD_EN)
//   finish    : level, high in DONE
//   running   : high in RUN
//   remaining : registered seconds left
module cook_timer
  import cook_timer_pkg::*;
#(
  parameter int SEC_DIV = SEC_DIV_DEF,
  parameter int TIME_W  = TIME_W_DEF,
  parameter int ADD_SEC = ADD_SEC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_valid,
  input  logic [TIME_W-1:0] set_time,
  input  logic              clear,
  input  logic              heat,
`ifdef COOK_TIMER_ADD_EN
  input  logic              add_time,
`endif
  output logic              finish,
  output logic              running,
  output logic [TIME_W-1:0] remaining
);

  localparam int CW = $clog2(SEC_DIV);

  // Saturating add of the quick-add amount; the carry out of the widened
  // sum flags overflow because ADD_SEC itself fits in TIME_W bits.
  function automatic logic [TIME_W-1:0] add_sat(input logic [TIME_W-1:0] v);
    logic [TIME_W:0] s;
    s = {1'b0, v} + (TIME_W+1)'(ADD_SEC);
    if (s[TIME_W]) return '1;
    else           return s[TIME_W-1:0];
  endfunction

  timer_state_t state, state_n;
  logic          tick;
  logic [CW-1:0] presc;
  logic          load_ok;
  logic          add_ok;
  logic          quick;
  logic          bump;
  logic          presc_en;
  logic          presc_clr;

  // Reload is accepted only outside an active cook and never for zero.
  assign load_ok = set_valid && !clear && (set_time != '0) &&
                   ((state == IDLE) || (state == ARMED) || (state == DONE));

`ifdef COOK_TIMER_ADD_EN
  assign add_ok = add_time && !clear && !set_valid;
`else
  assign add_ok = 1'b0;
`endif

  assign quick = add_ok && ((state == IDLE) || (state == DONE));
  assign bump  = add_ok && !quick;

  // A quick-add cycle in RUN leaves the prescaler untouched.
  assign presc_en  = (state == RUN) && heat && !bump;
  // Also scrub any stray prescaler value while ARMED so RUN starts at 0.
  assign presc_clr = clear || load_ok || quick ||
                     ((state == ARMED) && (presc != '0));

  tick_gen #(
    .SEC_DIV (SEC_DIV),
    .CW      (CW)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .en    (presc_en),
    .clr   (presc_clr),
    .tick  (tick),
    .count (presc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (clear) begin
      state_n = IDLE;
    end else if (load_ok || quick) begin
      state_n = ARMED;
    end else if (!bump) begin
      case (state)
        ARMED: if (heat) state_n = RUN;
        RUN: begin
          if (!heat)                            state_n = PAUSE;
          else if (tick && (remaining == TIME_W'(1))) state_n = DONE;
        end
        PAUSE: if (heat) state_n = RUN;
        default: state_n = state;
      endcase
    end
  end

  always_comb begin
    finish  = (state == DONE);
    running = (state == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining <= '0;
    end else if (clear) begin
      remaining <= '0;
    end else if (load_ok) begin
      remaining <= set_time;
    end else if (quick) begin
      remaining <= TIME_W'(ADD_SEC);
    end else if (bump) begin
      remaining <= add_sat(remaining);
    end else if (tick && (remaining != '0)) begin
      remaining <= remaining - 1'b1;
    end
  end

endmodule

// File: tb/tb_cook_timer.sv
module tb_cook_timer;

  localparam int SEC_DIV = 4;
  localparam int TIME_W  = 12;
  localparam int ADD_SEC = 30;

  logic              clk;
  logic              rst;
  logic              set_valid;
  logic [TIME_W-1:0] set_time;
  logic              clear;
  logic              heat;
`ifdef COOK_TIMER_ADD_EN
  logic              add_time;
`endif
  logic              finish;
  logic              running;
  logic [TIME_W-1:0] remaining;

  int n_cmp;
  int n_bad;

  logic [TIME_W+1:0] obs;
  logic [TIME_W+1:0] exp_v;

  cook_timer #(
    .SEC_DIV (SEC_DIV),
    .TIME_W  (TIME_W),
    .ADD_SEC (ADD_SEC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .set_valid (set_valid),
    .set_time  (set_time),
    .clear     (clear),
    .heat      (heat),
`ifdef COOK_TIMER_ADD_EN
    .add_time  (add_time),
`endif
    .finish    (finish),
    .running   (running),
    .remaining (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    obs = {finish, running, remaining};
    n_cmp++;
    if (obs !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got fin/run/rem=%b/%b/%0d want 0/0/0", finish, running, remaining);
    end
    rst = 1'b0;
    set_valid = 1'b1; set_time = 12'd5; heat = 1'b1;
    step();
    set_valid = 1'b0;
    step(); step(); step();
    n_cmp++;
    if ({running, remaining} !== {1'b1, 12'd5}) begin
      n_bad++;
      $display("FAIL reset_pre_run: got run=%b rem=%0d want run=1 rem=5", running, remaining);
    end
    #2 rst = 1'b1;
    #1;
    obs = {finish, running, remaining};
    n_cmp++;
    if (obs !== '0) begin
      n_bad++;
      $display("FAIL reset_async: got fin/run/rem=%b/%b/%0d want 0/0/0", finish, running, remaining);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      obs = {finish, running, remaining};
      n_cmp++;
      if (obs !== '0) begin
        n_bad++;
        $display("FAIL reset_stays_idle[%0d]: got fin/run/rem=%b/%b/%0d want 0/0/0", i, finish, running, remaining);
      end
    end
  endtask

  task automatic test_countdown();
    set_valid = 1'b1; set_time = 12'd3; heat = 1'b1;
    step();
    set_valid = 1'b0;
    n_cmp++;
    if ({running, remaining} !== {1'b0, 12'd3}) begin
      n_bad++;
      $display("FAIL cd_armed: got run=%b rem=%0d want run=0 rem=3", running, remaining);
    end
    step();
    n_cmp++;
    if ({running, remaining} !== {1'b1, 12'd3}) begin
      n_bad++;
      $display("FAIL cd_run_entry: got run=%b rem=%0d want run=1 rem=3", running, remaining);
    end
    for (int i = 1; i <= 12; i++) begin
      step();
      exp_v = {(i == 12), (i != 12), 12'(3 - i / 4)};
      obs = {finish, running, remaining};
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL cd_cycle[%0d]: got fin/run/rem=%b/%b/%0d want %b/%b/%0d",
                 i, finish, running, remaining, exp_v[TIME_W+1], exp_v[TIME_W], exp_v[TIME_W-1:0]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({finish, remaining} !== {1'b1, 12'd0}) begin
        n_bad++;
        $display("FAIL cd_hold[%0d]: got fin=%b rem=%0d want fin=1 rem=0", i, finish, remaining);
      end
    end
  endtask

  task automatic test_priority();
    clear = 1'b1; set_valid = 1'b1; set_time = 12'd9;
    step();
    clear = 1'b0; set_valid = 1'b0;
    obs = {finish, running, remaining};
    n_cmp++;
    if (obs !== '0) begin
      n_bad++;
      $display("FAIL prio_clear_wins: got fin/run/rem=%b/%b/%0d want 0/0/0", finish, running, remaining);
    end
    set_valid = 1'b1; set_time = 12'd0; heat = 1'b1;
    step();
    set_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      obs = {finish, running, remaining};
      n_cmp++;
      if (obs !== '0) begin
        n_bad++;
        $display("FAIL prio_zero_load[%0d]: got fin/run/rem=%b/%b/%0d want 0/0/0", i, finish, running, remaining);
      end
    end
  endtask

  task automatic test_pause();
    heat = 1'b0; set_valid = 1'b1; set_time = 12'd2;
    step();
    set_valid = 1'b0;
    heat = 1'b1;
    step();
    n_cmp++;
    if ({running, remaining} !== {1'b1, 12'd2}) begin
      n_bad++;
      $display("FAIL pause_run_entry: got run=%b rem=%0d want run=1 rem=2", running, remaining);
    end
    for (int i = 1; i <= 5; i++) step();
    n_cmp++;
    if ({running, remaining} !== {1'b1, 12'd1}) begin
      n_bad++;
      $display("FAIL pause_before: got run=%b rem=%0d want run=1 rem=1", running, remaining);
    end
    heat = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      obs = {finish, running, remaining};
      n_cmp++;
      if (obs !== {2'b00, 12'd1}) begin
        n_bad++;
        $display("FAIL pause_frozen[%0d]: got fin/run/rem=%b/%b/%0d want 0/0/1", i, finish, running, remaining);
      end
    end
    heat = 1'b1;
    step();
    for (int i = 1; i <= 3; i++) begin
      step();
      exp_v = (i == 3) ? {2'b10, 12'd0} : {2'b01, 12'd1};
      obs = {finish, running, remaining};
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL pause_resume[%0d]: got fin/run/rem=%b/%b/%0d want %b/%b/%0d",
                 i, finish, running, remaining, exp_v[TIME_W+1], exp_v[TIME_W], exp_v[TIME_W-1:0]);
      end
    end
  endtask

  task automatic test_done_hold();
    for (int i = 0; i < 6; i++) begin
      heat = (i % 2 == 1);
      step();
      n_cmp++;
      if ({finish, running, remaining} !== {2'b10, 12'd0}) begin
        n_bad++;
        $display("FAIL done_hold[%0d]: got fin/run/rem=%b/%b/%0d want 1/0/0", i, finish, running, remaining);
      end
    end
    heat = 1'b0; set_valid = 1'b1; set_time = 12'd4;
    step();
    set_valid = 1'b0;
    n_cmp++;
    if ({finish, running, remaining} !== {2'b00, 12'd4}) begin
      n_bad++;
      $display("FAIL done_reload: got fin/run/rem=%b/%b/%0d want 0/0/4", finish, running, remaining);
    end
    heat = 1'b1;
    step();
    n_cmp++;
    if ({running, remaining} !== {1'b1, 12'd4}) begin
      n_bad++;
      $display("FAIL done_rearmed: got run=%b rem=%0d want run=1 rem=4", running, remaining);
    end
  endtask

`ifdef COOK_TIMER_ADD_EN
  task automatic test_add();
    clear = 1'b1; heat = 1'b0;
    step();
    clear = 1'b0;
    add_time = 1'b1;
    step();
    add_time = 1'b0;
    n_cmp++;
    if ({running, remaining} !== {1'b0, 12'd30}) begin
      n_bad++;
      $display("FAIL add_quick: got run=%b rem=%0d want run=0 rem=30", running, remaining);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    set_valid = 1'b1; set_time = 12'd4080;
    step();
    set_valid = 1'b0; heat = 1'b1;
    step();
    add_time = 1'b1;
    step();
    add_time = 1'b0;
    n_cmp++;
    if ({running, remaining} !== {1'b1, 12'd4095}) begin
      n_bad++;
      $display("FAIL add_sat: got run=%b rem=%0d want run=1 rem=4095", running, remaining);
    end
    clear = 1'b1; heat = 1'b0;
    step();
    clear = 1'b0;
    add_time = 1'b1; set_valid = 1'b1; set_time = 12'd7;
    step();
    add_time = 1'b0; set_valid = 1'b0;
    n_cmp++;
    if (remaining !== 12'd7) begin
      n_bad++;
      $display("FAIL add_vs_load: got rem=%0d want rem=7", remaining);
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    set_valid = 1'b0;
    set_time = '0;
    clear = 1'b0;
    heat = 1'b0;
`ifdef COOK_TIMER_ADD_EN
    add_time = 1'b0;
`endif
    test_reset();
    test_countdown();
    test_priority();
    test_pause();
    test_done_hold();
`ifdef COOK_TIMER_ADD_EN
    test_add();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
